// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders; the only arithmetic cell of the serial datapath.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic partSum;
    logic partCarry;
    logic lateCarry;

    half_adder uHa0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (partSum),
        .c_o (partCarry)
    );

    half_adder uHa1 (
        .a_i (partSum),
        .b_i (cin_i),
        .s_o (sum_o),
        .c_o (lateCarry)
    );

    assign cout_o = partCarry | lateCarry;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: the basic cell that full_adder is composed from.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B: one full adder fed A and ~B with carry seeded to 1, LSB first over WIDTH cycles.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BORROW,
    output logic             OVF
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] dShift_q, dShift_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             aMsb_q, aMsb_d;
    logic             bMsb_q, bMsb_d;
    logic [WIDTH-1:0] dOut_q, dOut_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic faSum;
    logic faCout;

    full_adder uFa (
        .a_i    (aShift_q[0]),
        .b_i    (~bShift_q[0]),
        .cin_i  (carry_q),
        .sum_o  (faSum),
        .cout_o (faCout)
    );

    // Result registers load on the last RUN step so they are already valid in the DONE cycle.
    always_comb begin
        state_d  = state_q;
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        dShift_d = dShift_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        aMsb_d   = aMsb_q;
        bMsb_d   = bMsb_q;
        dOut_d   = dOut_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    aShift_d = A;
                    bShift_d = B;
                    carry_d  = 1'b1;
                    cnt_d    = '0;
                    aMsb_d   = A[WIDTH-1];
                    bMsb_d   = B[WIDTH-1];
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                aShift_d = {1'b0, aShift_q[WIDTH-1:1]};
                bShift_d = {1'b0, bShift_q[WIDTH-1:1]};
                dShift_d = {faSum, dShift_q[WIDTH-1:1]};
                carry_d  = faCout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    dOut_d   = {faSum, dShift_q[WIDTH-1:1]};
                    borrow_d = ~faCout;
                    ovf_d    = (aMsb_q ^ bMsb_q) & (faSum ^ aMsb_q);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            aShift_q <= '0;
            bShift_q <= '0;
            dShift_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            aMsb_q   <= 1'b0;
            bMsb_q   <= 1'b0;
            dOut_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            dShift_q <= dShift_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            aMsb_q   <= aMsb_d;
            bMsb_q   <= bMsb_d;
            dOut_q   <= dOut_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign BUSY   = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign DONE   = (state_q == ST_DONE);
    assign D      = dOut_q;
    assign BORROW = borrow_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor at WIDTH=8: results, handshake timing, and reset behaviour.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] D;
    logic             BORROW;
    logic             OVF;

    int compared   = 0;
    int mismatched = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .START  (START),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .D      (D),
        .BORROW (BORROW),
        .OVF    (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle 0 is the cycle START is driven; every sample is taken at a negedge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] dObs, output logic borrowObs,
                                 output logic ovfObs, output int doneCyc,
                                 output int doneCnt, output int busyErr,
                                 output logic [7:0] dHold);
        doneCyc = 0; doneCnt = 0; busyErr = 0;
        dObs = 'x; borrowObs = 1'bx; ovfObs = 1'bx; dHold = 'x;
        @(negedge clk);
        START = 1'b1; A = a; B = b;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                START = 1'b0; A = 8'hA5; B = 8'h5A;
            end
            if (BUSY !== (cyc <= 9)) busyErr++;
            if (DONE === 1'b1) begin
                doneCnt++;
                if (doneCyc == 0) begin
                    doneCyc = cyc; dObs = D; borrowObs = BORROW; ovfObs = OVF;
                end
            end
            if (cyc == 12) dHold = D;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; START = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        compared++;
        if ({BUSY, DONE, D, BORROW, OVF} !== 12'h000) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b d=%h borrow=%b ovf=%b, expected all zero",
                     BUSY, DONE, D, BORROW, OVF);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [7:0] va[5]   = '{8'h00, 8'h05, 8'h03, 8'h7F, 8'h80};
        logic [7:0] vb[5]   = '{8'h00, 8'h03, 8'h05, 8'hFF, 8'h01};
        logic [7:0] vd[5]   = '{8'h00, 8'h02, 8'hFE, 8'h80, 8'h7F};
        logic       vbor[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       vovf[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] dObs, dHold;
        logic borrowObs, ovfObs;
        int doneCyc, doneCnt, busyErr;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(va[i], vb[i], dObs, borrowObs, ovfObs, doneCyc, doneCnt, busyErr, dHold);
            compared += 7;
            if (dObs !== vd[i]) begin
                mismatched++;
                $display("[TB] FAIL vec%0d_d: got %h, expected %h", i, dObs, vd[i]);
            end
            if (borrowObs !== vbor[i]) begin
                mismatched++;
                $display("[TB] FAIL vec%0d_borrow: got %b, expected %b", i, borrowObs, vbor[i]);
            end
            if (ovfObs !== vovf[i]) begin
                mismatched++;
                $display("[TB] FAIL vec%0d_ovf: got %b, expected %b", i, ovfObs, vovf[i]);
            end
            if (doneCyc != 9) begin
                mismatched++;
                $display("[TB] FAIL vec%0d_done_cycle: got %0d, expected 9", i, doneCyc);
            end
            if (doneCnt != 1) begin
                mismatched++;
                $display("[TB] FAIL vec%0d_done_pulses: got %0d, expected 1", i, doneCnt);
            end
            if (busyErr != 0) begin
                mismatched++;
                $display("[TB] FAIL vec%0d_busy_window: got %0d bad cycles, expected 0", i, busyErr);
            end
            if (dHold !== vd[i]) begin
                mismatched++;
                $display("[TB] FAIL vec%0d_d_hold: got %h, expected %h", i, dHold, vd[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int doneCnt = 0;
        logic done9 = 1'b0, done19 = 1'b0, busy10 = 1'bx;
        logic [7:0] d9 = 'x, d19 = 'x;
        logic bor19 = 1'bx, ovf19 = 1'bx;
        @(negedge clk);
        START = 1'b1; A = 8'h10; B = 8'h01;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                A = 8'hFF; B = 8'hFF;
            end
            if (cyc == 11) START = 1'b0;
            if (DONE === 1'b1) doneCnt++;
            if (cyc == 9) begin
                done9 = DONE; d9 = D;
            end
            if (cyc == 10) busy10 = BUSY;
            if (cyc == 19) begin
                done19 = DONE; d19 = D; bor19 = BORROW; ovf19 = OVF;
            end
        end
        compared += 8;
        if (done9 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_done_c9: got %b, expected 1", done9);
        end
        if (d9 !== 8'h0F) begin
            mismatched++;
            $display("[TB] FAIL b2b_first_d: got %h, expected 0f", d9);
        end
        if (busy10 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_busy_c10: got %b, expected 0", busy10);
        end
        if (done19 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_done_c19: got %b, expected 1", done19);
        end
        if (d19 !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL b2b_second_d: got %h, expected 00", d19);
        end
        if (bor19 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_second_borrow: got %b, expected 0", bor19);
        end
        if (ovf19 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_second_ovf: got %b, expected 0", ovf19);
        end
        if (doneCnt != 2) begin
            mismatched++;
            $display("[TB] FAIL b2b_done_pulses: got %0d, expected 2", doneCnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int doneCnt = 0;
        logic [7:0] dObs, dHold;
        logic borrowObs, ovfObs;
        int doneCyc, freshCnt, busyErr;
        @(negedge clk);
        START = 1'b1; A = 8'h05; B = 8'h03;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) START = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        compared++;
        if ({BUSY, DONE, D, BORROW, OVF} !== 12'h000) begin
            mismatched++;
            $display("[TB] FAIL midrun_reset_outputs: got busy=%b done=%b d=%h borrow=%b ovf=%b, expected all zero",
                     BUSY, DONE, D, BORROW, OVF);
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (DONE === 1'b1) doneCnt++;
        end
        compared++;
        if (doneCnt != 0) begin
            mismatched++;
            $display("[TB] FAIL midrun_no_done: got %0d pulses, expected 0", doneCnt);
        end
        applyStimulus(8'h37, 8'h15, dObs, borrowObs, ovfObs, doneCyc, freshCnt, busyErr, dHold);
        compared += 3;
        if (dObs !== 8'h22 || borrowObs !== 1'b0 || ovfObs !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fresh_result: got d=%h borrow=%b ovf=%b, expected d=22 borrow=0 ovf=0",
                     dObs, borrowObs, ovfObs);
        end
        if (doneCyc != 9) begin
            mismatched++;
            $display("[TB] FAIL fresh_done_cycle: got %0d, expected 9", doneCyc);
        end
        if (busyErr != 0) begin
            mismatched++;
            $display("[TB] FAIL fresh_busy_window: got %0d bad cycles, expected 0", busyErr);
        end
    endtask

    task automatic test_reset_in_done();
        int doneCnt = 0;
        logic done9 = 1'bx;
        logic [7:0] d9 = 'x;
        @(negedge clk);
        START = 1'b1; A = 8'h03; B = 8'h05;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (cyc == 1) START = 1'b0;
            if (cyc == 9) begin
                done9 = DONE; d9 = D;
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        compared += 3;
        if (done9 !== 1'b1 || d9 !== 8'hFE) begin
            mismatched++;
            $display("[TB] FAIL done_cycle_before_reset: got done=%b d=%h, expected done=1 d=fe", done9, d9);
        end
        if ({BUSY, DONE, D, BORROW, OVF} !== 12'h000) begin
            mismatched++;
            $display("[TB] FAIL done_reset_outputs: got busy=%b done=%b d=%h borrow=%b ovf=%b, expected all zero",
                     BUSY, DONE, D, BORROW, OVF);
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (DONE === 1'b1) doneCnt++;
        end
        if (doneCnt != 0) begin
            mismatched++;
            $display("[TB] FAIL done_reset_no_pulse: got %0d pulses, expected 0", doneCnt);
        end
    endtask

    task automatic test_reset_with_start();
        int doneCnt = 0;
        @(negedge clk);
        rst_n = 1'b0; START = 1'b1; A = 8'h05; B = 8'h03;
        @(negedge clk);
        rst_n = 1'b1; START = 1'b0;
        compared += 2;
        if (BUSY !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_beats_start_busy: got %b, expected 0", BUSY);
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (DONE === 1'b1) doneCnt++;
        end
        if (doneCnt != 0) begin
            mismatched++;
            $display("[TB] FAIL reset_beats_start_done: got %0d pulses, expected 0", doneCnt);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_vectors();
        test_reset_mid_run();
        test_back_to_back();
        test_reset_in_done();
        test_reset_with_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
